// File: rtl/tlc_pkg.sv
// Shared types and lamp encodings for the four-phase intersection controller.
package tlc_pkg;

    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PH_NS_THRU = 2'd0,
        PH_EW_LEFT = 2'd1,
        PH_EW_THRU = 2'd2,
        PH_NS_LEFT = 2'd3
    } phase_e;

    // Lamp vector layout is {left, red, yellow, green}
    localparam int unsigned LAMP_GRN_BIT  = 0;
    localparam int unsigned LAMP_YEL_BIT  = 1;
    localparam int unsigned LAMP_RED_BIT  = 2;
    localparam int unsigned LAMP_LEFT_BIT = 3;

    localparam logic [3:0] LAMP_GRN  = 4'(1 << LAMP_GRN_BIT);
    localparam logic [3:0] LAMP_YEL  = 4'(1 << LAMP_YEL_BIT);
    localparam logic [3:0] LAMP_RED  = 4'(1 << LAMP_RED_BIT);
    localparam logic [3:0] LAMP_LEFT = 4'(1 << LAMP_LEFT_BIT);

    // True when the phase is served by the NS approach
    function automatic logic is_ns(phase_e p);
        return (p == PH_NS_THRU) || (p == PH_NS_LEFT);
    endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Round-robin next-phase selector: first pending phase after `last`, wrapping; phase 0 if none.
module tlc_rr_pick
    import tlc_pkg::*;
(
    input  logic [3:0] pend,
    input  phase_e     last,
    output phase_e     next
);

    logic       found;
    logic [1:0] idx;

    // Search last+1, last+2, last+3, last+0 and take the first pending phase
    always_comb begin
        next  = PH_NS_THRU;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = 2'(last) + 2'(k);
            if (!found && pend[idx]) begin
                next  = phase_e'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Demand-driven four-phase intersection controller.
// Optional emergency preemption is enabled by defining TLC_PREEMPT_EN.
module tlc_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int unsigned TW       = 8,
    parameter int unsigned GREEN_T  = 40,
    parameter int unsigned LEFT_T   = 20,
    parameter int unsigned YEL_T    = 5,
    parameter int unsigned ALLRED_T = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_i,
    input  logic [3:0] req_i,
`ifdef TLC_PREEMPT_EN
    input  logic       preempt_i,
    input  logic [1:0] preempt_phase_i,
`endif
    output logic [3:0] ns_lamp_o,
    output logic [3:0] ew_lamp_o,
    output logic [1:0] phase_o,
    output logic [3:0] pend_o,
    output logic       grant_o
);

    localparam longint unsigned TLIM = 64'd1 << TW;

    if (TW < 1 || TW > 31 ||
        GREEN_T < 1 || 64'(GREEN_T) >= TLIM || LEFT_T < 1 || 64'(LEFT_T) >= TLIM ||
        YEL_T < 1 || 64'(YEL_T) >= TLIM || ALLRED_T < 1 || 64'(ALLRED_T) >= TLIM)
    begin : g_bad_param
        $error("tlc_phase_scheduler: durations must be >= 1 and < 2**TW");
    end

    localparam logic [TW-1:0] GREEN_M1  = TW'(GREEN_T - 1);
    localparam logic [TW-1:0] LEFT_M1   = TW'(LEFT_T - 1);
    localparam logic [TW-1:0] YEL_M1    = TW'(YEL_T - 1);
    localparam logic [TW-1:0] ALLRED_M1 = TW'(ALLRED_T - 1);

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    pend_q, pend_d;
    logic [3:0]    ns_q, ns_d, ew_q, ew_d;
    logic          grant_q, grant_d;

    phase_e        rr_next, sel_phase;
    logic [TW-1:0] max_m1;
    logic [3:0]    cur_mask;
    logic          other_dem, preempt_kick, preempt_hold;

    tlc_rr_pick u_rr_pick (
        .pend (pend_q),
        .last (phase_q),
        .next (rr_next)
    );

    assign max_m1    = (phase_q == PH_NS_THRU || phase_q == PH_EW_THRU) ? GREEN_M1 : LEFT_M1;
    assign cur_mask  = 4'b0001 << phase_q;
    assign other_dem = |(pend_q & ~cur_mask);

`ifdef TLC_PREEMPT_EN
    // Preempting a different phase forces clearance; preempting the served phase pins it
    assign preempt_kick = preempt_i && (preempt_phase_i != 2'(phase_q));
    assign preempt_hold = preempt_i && (preempt_phase_i == 2'(phase_q));
    assign sel_phase    = preempt_i ? phase_e'(preempt_phase_i) : rr_next;
`else
    assign preempt_kick = 1'b0;
    assign preempt_hold = 1'b0;
    assign sel_phase    = rr_next;
`endif

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ALLRED;
            phase_q <= PH_NS_LEFT;
            timer_q <= '0;
            pend_q  <= '0;
            ns_q    <= LAMP_RED;
            ew_q    <= LAMP_RED;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            ns_q    <= ns_d;
            ew_q    <= ew_d;
            grant_q <= grant_d;
        end
    end

    // Next-state logic; intervals end on the tick where timer == duration-1
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        unique case (state_q)
            ALLRED: begin
                if (tick_i && timer_q == ALLRED_M1) begin
                    state_d = GREEN;
                    phase_d = sel_phase;
                end
            end
            GREEN: begin
                if (tick_i && !preempt_hold &&
                    (preempt_kick || (timer_q >= max_m1 && other_dem))) begin
                    state_d = YELLOW;
                end
            end
            YELLOW: begin
                if (tick_i && timer_q == YEL_M1) begin
                    state_d = ALLRED;
                end
            end
            default: state_d = ALLRED;
        endcase
    end

    // Interval timer and demand latch
    always_comb begin
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (tick_i && timer_q != {TW{1'b1}}) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end

        // Demand for the phase already showing green is dropped, not queued
        pend_d = pend_q | (req_i & ((state_q == GREEN) ? ~cur_mask : 4'b1111));
        if (state_d == GREEN && state_q != GREEN) begin
            pend_d = pend_d & ~(4'b0001 << phase_d);
        end
    end

    // Lamp and grant outputs, decoded from next state so they align with the state register
    always_comb begin
        ns_d    = LAMP_RED;
        ew_d    = LAMP_RED;
        grant_d = (state_d == GREEN) && (state_q != GREEN);
        unique case (state_d)
            GREEN: begin
                unique case (phase_d)
                    PH_NS_THRU: ns_d = LAMP_GRN;
                    PH_EW_LEFT: ew_d = LAMP_LEFT;
                    PH_EW_THRU: ew_d = LAMP_GRN;
                    PH_NS_LEFT: ns_d = LAMP_LEFT;
                endcase
            end
            YELLOW: begin
                if (is_ns(phase_d)) begin
                    ns_d = LAMP_YEL;
                end else begin
                    ew_d = LAMP_YEL;
                end
            end
            default: ;
        endcase
    end

    assign ns_lamp_o = ns_q;
    assign ew_lamp_o = ew_q;
    assign phase_o   = phase_q;
    assign pend_o    = pend_q;
    assign grant_o   = grant_q;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Directed bench for tlc_phase_scheduler: GREEN_T=4, LEFT_T=3, YEL_T=2, ALLRED_T=1,
// one tick every three clocks. Preemption vectors run when TLC_PREEMPT_EN is defined.
module tb_tlc_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_i = 1'b0;
    logic [3:0] req_i = 4'b0000;
    logic [3:0] ns_lamp_o, ew_lamp_o, pend_o;
    logic [1:0] phase_o;
    logic       grant_o;
`ifdef TLC_PREEMPT_EN
    logic       preempt_i = 1'b0;
    logic [1:0] preempt_phase_i = 2'd0;
`endif

    int n_checks = 0;
    int n_pass = 0;
    int onehot_bad = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    tlc_phase_scheduler #(
        .TW       (8),
        .GREEN_T  (4),
        .LEFT_T   (3),
        .YEL_T    (2),
        .ALLRED_T (1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tick_i          (tick_i),
        .req_i           (req_i),
`ifdef TLC_PREEMPT_EN
        .preempt_i       (preempt_i),
        .preempt_phase_i (preempt_phase_i),
`endif
        .ns_lamp_o       (ns_lamp_o),
        .ew_lamp_o       (ew_lamp_o),
        .phase_o         (phase_o),
        .pend_o          (pend_o),
        .grant_o         (grant_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle tick; returns at the negedge right after the tick edge
    task automatic tk();
        tick_i = 1'b1;
        @(negedge clk);
        tick_i = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            idle(2);
            tk();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic lamps(input string tag, input logic [3:0] ns, input logic [3:0] ew);
        check({tag, "_ns"}, 32'(ns_lamp_o), 32'(ns));
        check({tag, "_ew"}, 32'(ew_lamp_o), 32'(ew));
    endtask

    // Every cycle: one lamp per approach, never two conflicting movements at once
    always @(negedge clk) begin
        if (mon_en) begin
            if ($countones(ns_lamp_o) != 1 || $countones(ew_lamp_o) != 1 ||
                ((ns_lamp_o[0] | ns_lamp_o[3]) && (ew_lamp_o[0] | ew_lamp_o[3])))
                onehot_bad++;
        end
    end

    initial begin
        // Reset and rest in NS-through green
        do_reset();
        mon_en = 1'b1;
        lamps("rst", 4'b0100, 4'b0100);
        check("rst_phase", 32'(phase_o), 32'd3);
        check("rst_pend", 32'(pend_o), 32'd0);
        check("rst_grant", 32'(grant_o), 32'd0);
        ticks(1);
        lamps("g0", 4'b0001, 4'b0100);
        check("g0_grant", 32'(grant_o), 32'd1);
        check("g0_phase", 32'(phase_o), 32'd0);
        idle(1);
        check("g0_grant_drop", 32'(grant_o), 32'd0);
        ticks(6);
        lamps("g0_rest", 4'b0001, 4'b0100);
        check("g0_rest_grant", 32'(grant_o), 32'd0);

        // EW-through request at timer=1 waits for max
        do_reset();
        ticks(2);
        req_i = 4'b0100;
        idle(1);
        req_i = 4'b0000;
        check("t2_pend", 32'(pend_o), 32'h4);
        ticks(2);
        lamps("t2_hold", 4'b0001, 4'b0100);
        ticks(1);
        lamps("t2_yel", 4'b0010, 4'b0100);
        ticks(1);
        lamps("t2_yel2", 4'b0010, 4'b0100);
        ticks(1);
        lamps("t2_ar", 4'b0100, 4'b0100);
        ticks(1);
        lamps("t2_g2", 4'b0100, 4'b0001);
        check("t2_phase", 32'(phase_o), 32'd2);
        check("t2_pend0", 32'(pend_o), 32'd0);
        check("t2_grant", 32'(grant_o), 32'd1);

        // Round-robin over 1, 2, 3 then back to 0
        do_reset();
        ticks(1);
        req_i = 4'b1110;
        idle(1);
        req_i = 4'b0000;
        check("rr_pend", 32'(pend_o), 32'hE);
        ticks(4 + 3);
        lamps("rr_g1", 4'b0100, 4'b1000);
        check("rr_g1_phase", 32'(phase_o), 32'd1);
        check("rr_g1_pend", 32'(pend_o), 32'hC);
        ticks(2);
        lamps("rr_g1_hold", 4'b0100, 4'b1000);
        ticks(1);
        lamps("rr_y1", 4'b0100, 4'b0010);
        ticks(3);
        lamps("rr_g2", 4'b0100, 4'b0001);
        check("rr_g2_pend", 32'(pend_o), 32'h8);
        ticks(4);
        lamps("rr_y2", 4'b0100, 4'b0010);
        ticks(3);
        lamps("rr_g3", 4'b1000, 4'b0100);
        check("rr_g3_phase", 32'(phase_o), 32'd3);
        check("rr_g3_pend", 32'(pend_o), 32'd0);
        req_i = 4'b0001;
        idle(1);
        req_i = 4'b0000;
        ticks(3);
        lamps("rr_y3", 4'b0010, 4'b0100);
        ticks(3);
        lamps("rr_g0", 4'b0001, 4'b0100);
        check("rr_g0_phase", 32'(phase_o), 32'd0);
        ticks(8);
        lamps("rr_g0_rest", 4'b0001, 4'b0100);

        // Own-phase request ignored in green, latched in yellow
        do_reset();
        ticks(1);
        req_i = 4'b0011;
        idle(1);
        req_i = 4'b0001;
        check("own_green_pend", 32'(pend_o), 32'h2);
        ticks(4);
        lamps("own_yel", 4'b0010, 4'b0100);
        check("own_yel_edge_pend", 32'(pend_o), 32'h2);
        idle(1);
        check("own_yel_pend", 32'(pend_o), 32'h3);
        req_i = 4'b0000;

        // Reset in the middle of yellow
        ticks(1);
        lamps("mid_yel", 4'b0010, 4'b0100);
        rst_n = 1'b0;
        idle(1);
        lamps("mid_rst", 4'b0100, 4'b0100);
        check("mid_rst_pend", 32'(pend_o), 32'd0);
        check("mid_rst_phase", 32'(phase_o), 32'd3);
        check("mid_rst_grant", 32'(grant_o), 32'd0);
        rst_n = 1'b1;
        ticks(1);
        lamps("mid_rst_g0", 4'b0001, 4'b0100);
        check("mid_rst_g0_grant", 32'(grant_o), 32'd1);

`ifdef TLC_PREEMPT_EN
        // Preempt to EW-through from phase-0 green at timer=1
        do_reset();
        ticks(2);
        preempt_i = 1'b1;
        preempt_phase_i = 2'd2;
        req_i = 4'b0010;
        idle(1);
        req_i = 4'b0000;
        ticks(1);
        lamps("pe_yel", 4'b0010, 4'b0100);
        ticks(2);
        lamps("pe_ar", 4'b0100, 4'b0100);
        ticks(1);
        lamps("pe_g2", 4'b0100, 4'b0001);
        check("pe_g2_phase", 32'(phase_o), 32'd2);
        check("pe_g2_pend", 32'(pend_o), 32'h2);
        ticks(10);
        lamps("pe_hold", 4'b0100, 4'b0001);
        preempt_i = 1'b0;
        ticks(1);
        lamps("pe_rel_yel", 4'b0100, 4'b0010);
        ticks(2);
        lamps("pe_rel_ar", 4'b0100, 4'b0100);
        ticks(1);
        lamps("pe_g1", 4'b0100, 4'b1000);
        check("pe_g1_phase", 32'(phase_o), 32'd1);
`endif

        idle(2);
        check("lamp_onehot", 32'(onehot_bad), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
